shift_accum: RTL and testbench

- Downstream consumer of the 8-bit shifted-sample stage.
- Accepts registered samples on a valid/ready stream and sums groups of COUNT samples.
- Presents each sum with its sample count on an output valid/ready stream; one output holding register lets accumulation overlap a stalled output.
- A flush pulse emits a partial group early.

---
 rtl/shift_accum_if.sv | 39 +++
 rtl/shift_accum.sv | 123 ++++++++++++
 tb/tb_shift_accum.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_accum_if.sv
// shift_accum_if: bundles the sample input stream, the flush request, the
// sum output stream and a debug view of the controller state.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holding valid=1 keeps its
// payload stable until the transfer. ready may depend combinationally on
// the consumer's own inputs, but never on the same stream's valid.
//
//   in_data / in_valid / in_ready : sample stream into the accumulator
//   flush                         : single-cycle request to emit a partial group
//   out_sum / out_cnt / out_valid / out_ready : group result stream
//   dbg_state                     : 1 while a flush is pending
//
// Modports: master = the environment around the block, slave = shift_accum.
interface shift_accum_if #(
   parameter int DATA_W = 8,
   parameter int SUM_W  = 10,
   parameter int CNT_W  = 3
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              flush;
   logic [SUM_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_cnt;
   logic              out_valid;
   logic              out_ready;
   logic              dbg_state;

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_sum, out_cnt, out_valid, dbg_state
   );

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_sum, out_cnt, out_valid, dbg_state
   );
endinterface

// File: rtl/shift_accum.sv
// shift_accum: sums groups of COUNT unsigned samples and presents each sum
// with its sample count through a single output holding register, so the
// next group can accumulate while the current result waits on a stalled
// consumer. A flush pulse emits the partial group early.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : shift_accum_if.slave (sample stream, flush, result stream, debug)
//
// Sums wrap modulo 2^SUM_W.
module shift_accum #(
   parameter int DATA_W = 8,
   parameter int COUNT  = 4,
   parameter int SUM_W  = 10,
   parameter int CNT_W  = 3
) (
   input logic         clk,
   input logic         rst,
   shift_accum_if.slave bus
);
   typedef enum logic {
      S_ACCUM = 1'b0,   // accepting samples
      S_FLUSH = 1'b1    // partial group waiting for the output register
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(COUNT);

   state_t            state, state_nxt;
   logic [SUM_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic [SUM_W-1:0]  out_sum_r;
   logic [CNT_W-1:0]  out_cnt_r;
   logic              out_valid_r;

   logic              out_free;
   logic              at_last;
   logic              take;
   logic              in_ready_c;
   logic              accept;
   logic              complete;
   logic              load_part;
   logic [SUM_W-1:0]  in_ext;

   assign in_ext   = {{(SUM_W-DATA_W){1'b0}}, bus.in_data};
   // The holding register can take a new value this cycle if it is empty
   // or being emptied by the consumer right now.
   assign out_free = !out_valid_r || bus.out_ready;
   assign at_last  = (cnt == LAST);
   assign take     = out_valid_r && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready_c = 1'b0;
      load_part  = 1'b0;
      case (state)
         S_ACCUM: begin
            // The group-completing sample needs the holding register free.
            in_ready_c = !(at_last && !out_free);
            // Arm only if there is something to emit after this cycle's
            // accept and that accept does not already close a full group.
            if (bus.flush &&
                ((cnt != '0) || (bus.in_valid && in_ready_c)) &&
                !(bus.in_valid && in_ready_c && at_last))
               state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (out_free) begin
               load_part = 1'b1;
               state_nxt = S_ACCUM;
            end
         end
         default: state_nxt = S_ACCUM;
      endcase
   end

   assign accept   = bus.in_valid && in_ready_c;
   assign complete = accept && at_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         out_sum_r   <= '0;
         out_cnt_r   <= '0;
         out_valid_r <= 1'b0;
      end else begin
         if (complete || load_part) begin
            acc <= '0;
            cnt <= '0;
         end else if (accept) begin
            acc <= acc + in_ext;
            cnt <= cnt + CNT_W'(1);
         end

         // A load overrides a same-cycle take, keeping back-to-back groups
         // at full rate.
         if (complete) begin
            out_sum_r   <= acc + in_ext;
            out_cnt_r   <= FULL;
            out_valid_r <= 1'b1;
         end else if (load_part) begin
            out_sum_r   <= acc;
            out_cnt_r   <= cnt;
            out_valid_r <= 1'b1;
         end else if (take) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_sum   = out_sum_r;
   assign bus.out_cnt   = out_cnt_r;
   assign bus.out_valid = out_valid_r;
   assign bus.dbg_state = (state == S_FLUSH);
endmodule

// File: tb/tb_shift_accum.sv
module tb_shift_accum;
  localparam int DATA_W = 8;
  localparam int COUNT  = 4;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 3;
  localparam int W      = SUM_W + CNT_W;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_accum_if #(.DATA_W(DATA_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) bus ();

  shift_accum #(.DATA_W(DATA_W), .COUNT(COUNT), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------
  // Reference model + scoreboard. Sampled at negedge (inputs are driven
  // just after posedge). The model keeps the current group as a list of
  // samples; a group is closed by reaching COUNT samples or by a flush,
  // and its (sum mod 2^SUM_W, size) is queued as the next expected result.
  // ---------------------------------------------------------------
  logic [W-1:0]      exp_q[$];
  int                grp[$];
  bit                pend_m;
  bit                stall_prev;
  logic [W-1:0]      held;

  function automatic logic [W-1:0] pack_grp();
    int s;
    s = 0;
    foreach (grp[i]) s += grp[i];
    return {SUM_W'(s % (1 << SUM_W)), CNT_W'(grp.size())};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      grp.delete();
      exp_q.delete();
      pend_m     = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_sum, bus.out_cnt} !== held) begin
          failures++;
          $display("FAIL hold_stable got v=%b sum/cnt=%h exp v=1 sum/cnt=%h", bus.out_valid, {bus.out_sum, bus.out_cnt}, held);
        end
      end
      if (pend_m) begin
        if (exp_q.size() == 1 && bus.out_valid === 1'b1) pend_m = 1'b0;
        else begin
          checks++;
          if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL pend_in_ready got %b exp 0", bus.in_ready);
          end
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL take_unexpected got sum=%0d cnt=%0d exp no output", bus.out_sum, bus.out_cnt);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({bus.out_sum, bus.out_cnt} !== e) begin
            failures++;
            $display("FAIL take_value got sum=%0d cnt=%0d exp sum=%0d cnt=%0d", bus.out_sum, bus.out_cnt, e[W-1:CNT_W], e[CNT_W-1:0]);
          end
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) grp.push_back(int'(bus.in_data));
      if (grp.size() == COUNT) begin
        exp_q.push_back(pack_grp());
        grp.delete();
      end else if (bus.flush === 1'b1 && grp.size() > 0 && !pend_m) begin
        exp_q.push_back(pack_grp());
        grp.delete();
        pend_m = 1'b1;
      end
      stall_prev = (bus.out_valid === 1'b1 && bus.out_ready !== 1'b1);
      held       = {bus.out_sum, bus.out_cnt};
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.out_cnt !== '0 || bus.in_ready !== 1'b1 || bus.dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b sum=%0d cnt=%0d rdy=%b st=%b exp v=0 sum=0 cnt=0 rdy=1 st=0",
               bus.out_valid, bus.out_sum, bus.out_cnt, bus.in_ready, bus.dbg_state);
    end
  endtask

  task automatic test_full_group();
    for (int i = 0; i < 4; i++) begin
      step();
      bus.in_valid = 1'b1; bus.in_data = DATA_W'(4 * (i + 1)); bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL full_group_fill[%0d] got rdy=%b v=%b exp rdy=1 v=0", i, bus.in_ready, bus.out_valid);
      end
    end
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd40 || bus.out_cnt !== 3'd4 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_group_out got v=%b sum=%0d cnt=%0d rdy=%b exp v=1 sum=40 cnt=4 rdy=1", bus.out_valid, bus.out_sum, bus.out_cnt, bus.in_ready);
    end
    step();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_group_one_cycle got v=%b exp 0", bus.out_valid);
    end
    idle(2);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 9; i++) begin
      step();
      bus.in_valid = 1'b1; bus.in_data = 8'hFC; bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== (i < 7)) begin
        failures++;
        $display("FAIL stall_in_ready[%0d] got %b exp %b", i, bus.in_ready, (i < 7));
      end
      if (i >= 4) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd1008 || bus.out_cnt !== 3'd4) begin
          failures++;
          $display("FAIL stall_held[%0d] got v=%b sum=%0d cnt=%0d exp v=1 sum=1008 cnt=4", i, bus.out_valid, bus.out_sum, bus.out_cnt);
        end
      end
    end
    step();
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready got %b exp 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd1008 || bus.out_cnt !== 3'd4) begin
      failures++;
      $display("FAIL stall_second got v=%b sum=%0d cnt=%0d exp v=1 sum=1008 cnt=4", bus.out_valid, bus.out_sum, bus.out_cnt);
    end
    step();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain got v=%b exp 0", bus.out_valid);
    end
    idle(2);
  endtask

  task automatic test_flush();
    step(); bus.in_valid = 1'b1; bus.in_data = 8'd3; bus.out_ready = 1'b1;
    step(); bus.in_data = 8'd5;
    step(); bus.in_valid = 1'b0; bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_cycle_ready got %b exp 1", bus.in_ready);
    end
    step(); bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.dbg_state !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_pending got rdy=%b st=%b v=%b exp rdy=0 st=1 v=0", bus.in_ready, bus.dbg_state, bus.out_valid);
    end
    step();
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd8 || bus.out_cnt !== 3'd2 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_out got v=%b sum=%0d cnt=%0d rdy=%b exp v=1 sum=8 cnt=2 rdy=1", bus.out_valid, bus.out_sum, bus.out_cnt, bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step(); bus.in_valid = 1'b1; bus.in_data = 8'd6;
    end
    step(); bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd24 || bus.out_cnt !== 3'd4) begin
      failures++;
      $display("FAIL flush_restart got v=%b sum=%0d cnt=%0d exp v=1 sum=24 cnt=4", bus.out_valid, bus.out_sum, bus.out_cnt);
    end
    idle(2);
  endtask

  task automatic test_flush_ignored();
    step(); bus.in_valid = 1'b0; bus.flush = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty_ready got %b exp 1", bus.in_ready);
    end
    step(); bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty_after got v=%b rdy=%b st=%b exp v=0 rdy=1 st=0", bus.out_valid, bus.in_ready, bus.dbg_state);
    end
    for (int i = 0; i < 4; i++) begin
      step(); bus.in_valid = 1'b1; bus.in_data = 8'd1; bus.flush = (i == 3);
    end
    step(); bus.in_valid = 1'b0; bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd4 || bus.out_cnt !== 3'd4 || bus.dbg_state !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full_out got v=%b sum=%0d cnt=%0d st=%b rdy=%b exp v=1 sum=4 cnt=4 st=0 rdy=1",
               bus.out_valid, bus.out_sum, bus.out_cnt, bus.dbg_state, bus.in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_full_no_second[%0d] got v=%b exp 0", i, bus.out_valid);
      end
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    // Leave a full group held and a partial group (7, 9) in flight.
    for (int i = 0; i < 4; i++) begin
      step(); bus.in_valid = 1'b1; bus.in_data = 8'd1; bus.out_ready = 1'b0;
    end
    step(); bus.in_data = 8'd7;
    step(); bus.in_data = 8'd9;
    step(); bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got v=%b sum=%0d rdy=%b exp v=0 sum=0 rdy=1", bus.out_valid, bus.out_sum, bus.in_ready);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); bus.in_valid = 1'b1; bus.in_data = DATA_W'(i + 1); bus.out_ready = 1'b1;
    end
    step(); bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd10 || bus.out_cnt !== 3'd4) begin
      failures++;
      $display("FAIL reset_clean_group got v=%b sum=%0d cnt=%0d exp v=1 sum=10 cnt=4", bus.out_valid, bus.out_sum, bus.out_cnt);
    end
    idle(2);
  endtask

  task automatic test_flush_stalled();
    for (int i = 0; i < 4; i++) begin
      step(); bus.in_valid = 1'b1; bus.in_data = 8'h10; bus.out_ready = 1'b0;
    end
    step(); bus.in_data = 8'hFF;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd64 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fstall_held got v=%b sum=%0d rdy=%b exp v=1 sum=64 rdy=1", bus.out_valid, bus.out_sum, bus.in_ready);
    end
    step(); bus.in_valid = 1'b0; bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fstall_flush_ready got %b exp 1", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(); bus.flush = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.dbg_state !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_sum !== 10'd64 || bus.out_cnt !== 3'd4) begin
        failures++;
        $display("FAIL fstall_pend[%0d] got rdy=%b st=%b v=%b sum=%0d cnt=%0d exp rdy=0 st=1 v=1 sum=64 cnt=4",
                 i, bus.in_ready, bus.dbg_state, bus.out_valid, bus.out_sum, bus.out_cnt);
      end
    end
    step(); bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fstall_take_ready got %b exp 0", bus.in_ready);
    end
    step();
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd255 || bus.out_cnt !== 3'd1 || bus.in_ready !== 1'b1 || bus.dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL fstall_partial got v=%b sum=%0d cnt=%0d rdy=%b st=%b exp v=1 sum=255 cnt=1 rdy=1 st=0",
               bus.out_valid, bus.out_sum, bus.out_cnt, bus.in_ready, bus.dbg_state);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      step();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = DATA_W'($urandom);
      bus.flush     = ($urandom_range(0, 11) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    // Push out any open partial group, then drain the output register.
    step(); bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    step(); bus.flush = 1'b1;
    step(); bus.flush = 1'b0;
    idle(8);
    checks++;
    if (exp_q.size() != 0 || grp.size() != 0) begin
      failures++;
      $display("FAIL random_drain got pending_results=%0d open_samples=%0d exp 0 and 0", exp_q.size(), grp.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_group();
    test_stall();
    test_flush();
    test_flush_ignored();
    test_async_reset();
    test_flush_stalled();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
